// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory access path: size encodings,
// byte-enable and misalignment helpers, and the load response record.
package riscv_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;   // 2'b11 also decodes as word

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    // Captured at every read-type grant, consumed one cycle later.
    typedef struct packed {
        owner_e     owner;
        logic [1:0] size;
        logic [1:0] offset;
        logic       uns;
        logic       err;
    } resp_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << offset;
            SZ_HALF: byte_en = offset[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = offset[0];
            default: misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the data-memory arbiter: core port, debug port and the
// single-port memory side. "slave" is the arbiter's view, "master" is the
// surrounding system (core, debug/loader and the memory itself).
interface dmem_arbiter_if #(parameter int MEM_AW = 10);

    logic              core_req;
    logic              core_we;
    logic [31:0]       core_addr;
    logic [1:0]        core_size;
    logic              core_unsigned;
    logic [31:0]       core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [31:0]       core_rdata;
    logic              core_err;

    logic              dbg_req;
    logic              dbg_we;
    logic [31:0]       dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_lock;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_size, core_unsigned, core_wdata,
        output core_gnt, core_rvalid, core_rdata, core_err,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_size, core_unsigned, core_wdata,
        input  core_gnt, core_rvalid, core_rdata, core_err,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Purely combinational byte-lane handling: steers store data onto the
// memory lanes with matching byte enables, and extracts/extends load data
// from a raw memory word.
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_uns,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicate the low byte/half across lanes; enables pick the live lane.
    always_comb begin
        st_be = byte_en(st_size, st_offset);
        case (st_size)
            SZ_BYTE: st_wdata = {4{st_data[7:0]}};
            SZ_HALF: st_wdata = {2{st_data[15:0]}};
            default: st_wdata = st_data;
        endcase
    end

    // Pick the addressed byte/half and sign- or zero-extend it.
    always_comb begin
        ld_shift = ld_word >> {ld_offset, 3'b000};
        ld_byte  = ld_shift[7:0];
        ld_half  = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_uns & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{~ld_uns & ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store path and a debug/loader
// port. Grants are combinational; load data returns one cycle after grant.
// Build option: define DMEM_ARB_DBG_EN to enable the debug port; otherwise
// debug inputs are ignored and the core owns the memory outright.
module dmem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int MEM_AW     = 10
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    logic        core_gnt;
    logic        dbg_gnt;
    logic        core_mis;
    logic        core_rd;
    logic        dbg_rd;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    resp_t       resp_q;
    logic        resp_vld;
    logic        core_rv;
    logic        dbg_rv;

    assign core_mis = misaligned(bus.core_size, bus.core_addr[1:0]);

`ifdef DMEM_ARB_DBG_EN
    logic [3:0] dbg_wait;
    logic       dbg_owner;
    logic       dbg_pri;

    assign dbg_pri = dbg_owner | (dbg_wait == 4'(STARVE_MAX));
    assign dbg_gnt = rst & bus.dbg_req & (dbg_pri | ~bus.core_req);

    // Starvation counter and lock ownership for the debug port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dbg_wait  <= '0;
            dbg_owner <= 1'b0;
        end else begin
            if (dbg_gnt || !bus.dbg_req)
                dbg_wait <= '0;
            else if (dbg_wait != 4'(STARVE_MAX))
                dbg_wait <= dbg_wait + 4'd1;
            if (!bus.dbg_req || !bus.dbg_lock)
                dbg_owner <= 1'b0;
            else if (dbg_gnt)
                dbg_owner <= 1'b1;
        end
    end
`else
    logic unused_dbg;
    assign dbg_gnt    = 1'b0;
    assign unused_dbg = ^{bus.dbg_req, bus.dbg_we, bus.dbg_lock, bus.dbg_wdata, 4'(STARVE_MAX)};
`endif

    // Outputs are held at zero while reset is asserted, hence the rst terms.
    assign core_gnt = rst & bus.core_req & ~dbg_gnt;

    // Misaligned core accesses return an error response whether load or store.
    assign core_rd = core_gnt & (~bus.core_we | core_mis);
    assign dbg_rd  = dbg_gnt & ~bus.dbg_we;

    logic unused_addr;
    assign unused_addr = ^{bus.core_addr[31:MEM_AW+2], bus.dbg_addr[31:MEM_AW+2], bus.dbg_addr[1:0]};

    dmem_lane_align u_align (
        .st_size   (bus.core_size),
        .st_offset (bus.core_addr[1:0]),
        .st_data   (bus.core_wdata),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .ld_size   (resp_q.size),
        .ld_offset (resp_q.offset),
        .ld_uns    (resp_q.uns),
        .ld_word   (bus.mem_rdata),
        .ld_data   (ld_data)
    );

    // Drive the memory from whichever requester holds the grant this cycle.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (dbg_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.dbg_we ? 4'b1111 : 4'b0000;
            bus.mem_addr  = bus.dbg_addr[MEM_AW+1:2];
            bus.mem_wdata = bus.dbg_wdata;
        end else if (core_gnt && !core_mis) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.core_we ? st_be : 4'b0000;
            bus.mem_addr  = bus.core_addr[MEM_AW+1:2];
            bus.mem_wdata = st_wdata;
        end
    end

    // Remember who asked and how to format the word arriving next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_vld <= 1'b0;
            resp_q   <= '0;
        end else begin
            resp_vld <= core_rd | dbg_rd;
            if (core_rd)
                resp_q <= '{owner: OWN_CORE, size: bus.core_size, offset: bus.core_addr[1:0],
                            uns: bus.core_unsigned, err: core_mis};
            else if (dbg_rd)
                resp_q <= '{owner: OWN_DBG, size: SZ_WORD, offset: 2'b00, uns: 1'b0, err: 1'b0};
        end
    end

    assign core_rv = rst & resp_vld & (resp_q.owner == OWN_CORE);
    assign dbg_rv  = rst & resp_vld & (resp_q.owner == OWN_DBG);

    // Response outputs; rdata is forced to zero outside its valid cycle.
    always_comb begin
        bus.core_gnt    = core_gnt;
        bus.core_rvalid = core_rv;
        bus.core_err    = core_rv & resp_q.err;
        bus.core_rdata  = (core_rv && !resp_q.err) ? ld_data : 32'h0;
`ifdef DMEM_ARB_DBG_EN
        bus.dbg_gnt     = dbg_gnt;
        bus.dbg_rvalid  = dbg_rv;
        bus.dbg_rdata   = dbg_rv ? bus.mem_rdata : 32'h0;
`else
        bus.dbg_gnt     = 1'b0;
        bus.dbg_rvalid  = 1'b0;
        bus.dbg_rdata   = 32'h0;
`endif
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed lane-formatting vectors, arbitration and
// reset sequences, then randomized traffic against a byte-level memory model.
module tb_dmem_arbiter;
    localparam int STARVE = 4;
    localparam int AW     = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.MEM_AW(AW)) bus ();

    dmem_arbiter #(.STARVE_MAX(STARVE), .MEM_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural memory attached to the arbiter, with an override for vectors.
    bit [31:0]   tbmem [1024];
    bit [31:0]   mem_q;
    bit          force_rd = 1'b0;
    logic [31:0] rd_force = 32'h0;
    assign bus.mem_rdata = force_rd ? rd_force : mem_q;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_we[i]) tbmem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            mem_q <= tbmem[bus.mem_addr];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Stimulus shadows.
    logic        c_req = 0, c_we = 0, c_uns = 0;
    logic [31:0] c_addr = 0, c_wdata = 0;
    logic [1:0]  c_size = 0;
    logic        d_req = 0, d_we = 0, d_lock = 0;
    logic [31:0] d_addr = 0, d_wdata = 0;

    task automatic drive();
        bus.core_req = c_req;  bus.core_we = c_we;  bus.core_addr = c_addr;
        bus.core_size = c_size; bus.core_unsigned = c_uns; bus.core_wdata = c_wdata;
        bus.dbg_req = d_req;   bus.dbg_we = d_we;   bus.dbg_addr = d_addr;
        bus.dbg_wdata = d_wdata; bus.dbg_lock = d_lock;
    endtask

    task automatic do_reset();
        rst = 1'b0; c_req = 0; d_req = 0; d_lock = 0; drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Byte-addressed reference memory for the random phase.
    bit [7:0] ref_mem [4096];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ld_model(input int a, input int n, input bit uns);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic [9:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_rv;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [11];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int m_wait; bit m_owner; bit e_core, e_dbg, mis, found;
        bit pc_v, pc_e, pd_v; logic [31:0] pc_d, pd_d;
        int n, wa;

        vt[0]  = '{1, 32'h103, 2'd0, 0, 32'h000000A5, 32'h0, 1, 4'b1000, 10'h40, 32'hA5A5A5A5, 0, 32'h0, 0};
        vt[1]  = '{0, 32'h102, 2'd1, 0, 32'h0, 32'h80017F00, 1, 4'b0000, 10'h40, 32'h0, 1, 32'hFFFF8001, 0};
        vt[2]  = '{0, 32'h102, 2'd1, 1, 32'h0, 32'h80017F00, 1, 4'b0000, 10'h40, 32'h0, 1, 32'h00008001, 0};
        vt[3]  = '{0, 32'h101, 2'd2, 0, 32'h0, 32'h12345678, 0, 4'b0000, 10'h0, 32'h0, 1, 32'h0, 1};
        vt[4]  = '{1, 32'h006, 2'd1, 0, 32'h1234BEEF, 32'h0, 1, 4'b1100, 10'h1, 32'hBEEFBEEF, 0, 32'h0, 0};
        vt[5]  = '{1, 32'h008, 2'd2, 0, 32'hDEADBEEF, 32'h0, 1, 4'b1111, 10'h2, 32'hDEADBEEF, 0, 32'h0, 0};
        vt[6]  = '{0, 32'h001, 2'd0, 0, 32'h0, 32'h000080FF, 1, 4'b0000, 10'h0, 32'h0, 1, 32'hFFFFFF80, 0};
        vt[7]  = '{0, 32'h003, 2'd0, 1, 32'h0, 32'h9A000000, 1, 4'b0000, 10'h0, 32'h0, 1, 32'h0000009A, 0};
        vt[8]  = '{1, 32'h003, 2'd1, 0, 32'h0000FFFF, 32'h0, 0, 4'b0000, 10'h0, 32'h0, 1, 32'h0, 1};
        vt[9]  = '{0, 32'h00C, 2'd3, 0, 32'h0, 32'h12345678, 1, 4'b0000, 10'h3, 32'h0, 1, 32'h12345678, 0};
        vt[10] = '{1, 32'h000, 2'd0, 0, 32'h12345677, 32'h0, 1, 4'b0001, 10'h0, 32'h77777777, 0, 32'h0, 0};

        // Reset state with both requesters active.
        c_req = 1; c_addr = 32'h800; c_size = 2'd2; d_req = 1; d_addr = 32'h900;
        rst = 1'b0; drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_core_gnt", 32'(bus.core_gnt), 0);
        chk("rst_dbg_gnt", 32'(bus.dbg_gnt), 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_core_rvalid", 32'(bus.core_rvalid), 0);
        chk("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 0);
        do_reset();

        // Lane formatting vectors, core alone.
        force_rd = 1'b1;
        for (int i = 0; i < 11; i++) begin
            c_req = 1; c_we = vt[i].we; c_addr = vt[i].addr; c_size = vt[i].size;
            c_uns = vt[i].uns; c_wdata = vt[i].wdata; rd_force = vt[i].rdata; drive();
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), 32'(bus.core_gnt), 1);
            chk($sformatf("v%0d_en", i), 32'(bus.mem_en), 32'(vt[i].exp_en));
            chk($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'(vt[i].exp_we));
            if (vt[i].exp_en) chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr), 32'(vt[i].exp_addr));
            if (vt[i].exp_en && vt[i].we) chk($sformatf("v%0d_wdata", i), bus.mem_wdata, vt[i].exp_wdata);
            @(posedge clk); #1 c_req = 0; drive();
            @(negedge clk);
            chk($sformatf("v%0d_rvalid", i), 32'(bus.core_rvalid), 32'(vt[i].exp_rv));
            if (vt[i].exp_rv) begin
                chk($sformatf("v%0d_rdata", i), bus.core_rdata, vt[i].exp_rdata);
                chk($sformatf("v%0d_err", i), 32'(bus.core_err), 32'(vt[i].exp_err));
            end
            @(posedge clk); #1;
        end
        force_rd = 1'b0;

`ifdef DMEM_ARB_DBG_EN
        // Starvation: core streams loads, debug waits STARVE cycles then wins once.
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h800; c_size = 2'd2;
        d_req = 1; d_we = 0; d_addr = 32'h900; d_lock = 0; drive();
        for (int k = 1; k <= STARVE + 2; k++) begin
            @(negedge clk);
            chk($sformatf("starve_c%0d_dbg_gnt", k), 32'(bus.dbg_gnt), 32'(k == STARVE + 1));
            chk($sformatf("starve_c%0d_core_gnt", k), 32'(bus.core_gnt), 32'(k != STARVE + 1));
            @(posedge clk); #1;
        end

        // Locked debug burst of three reads against a busy core.
        do_reset();
        c_req = 1; d_req = 1; d_lock = 1; d_addr = 32'h904; drive();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.dbg_gnt) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("lock_first_gnt", 32'(found), 1);
        for (int k = 2; k <= 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("lock_g%0d_dbg_gnt", k), 32'(bus.dbg_gnt), 1);
            chk($sformatf("lock_g%0d_core_gnt", k), 32'(bus.core_gnt), 0);
            chk($sformatf("lock_g%0d_rvalid", k), 32'(bus.dbg_rvalid), 1);
        end
        @(posedge clk); #1 d_req = 0; d_lock = 0; drive();
        @(negedge clk);
        chk("lock_end_rvalid", 32'(bus.dbg_rvalid), 1);
        chk("lock_end_core_gnt", 32'(bus.core_gnt), 1);
        chk("lock_end_dbg_gnt", 32'(bus.dbg_gnt), 0);
        @(posedge clk); #1;
`else
        // Debug port inert: never granted, core always granted.
        do_reset();
        c_req = 0; d_req = 1; d_we = 0; d_addr = 32'h900; drive();
        @(negedge clk);
        chk("nodbg_dbg_gnt", 32'(bus.dbg_gnt), 0);
        chk("nodbg_mem_en", 32'(bus.mem_en), 0);
        @(posedge clk); #1 c_req = 1; c_we = 0; c_addr = 32'h800; c_size = 2'd2; drive();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("nodbg_c%0d_core_gnt", k), 32'(bus.core_gnt), 1);
            chk($sformatf("nodbg_c%0d_dbg_rv", k), 32'(bus.dbg_rvalid), 0);
            @(posedge clk); #1;
        end
`endif

        // Reset in the grant cycle, then reset with a load in flight.
        do_reset();
        d_req = 0; c_req = 1; c_we = 0; c_addr = 32'h800; c_size = 2'd2;
        rst = 1'b0; drive();
        @(negedge clk);
        chk("rstg_core_gnt", 32'(bus.core_gnt), 0);
        chk("rstg_mem_en", 32'(bus.mem_en), 0);
        @(posedge clk); #1 rst = 1'b1; c_req = 0; drive();
        @(negedge clk);
        chk("rstg_no_rvalid", 32'(bus.core_rvalid), 0);
        @(posedge clk); #1 c_req = 1; drive();
        @(negedge clk);
        chk("rstf_core_gnt", 32'(bus.core_gnt), 1);
        @(posedge clk); #1 rst = 1'b0; c_req = 0; drive();
        @(negedge clk);
        chk("rstf_rvalid_in_rst", 32'(bus.core_rvalid), 0);
        chk("rstf_rdata_in_rst", bus.core_rdata, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rstf_rvalid_after", 32'(bus.core_rvalid), 0);

        // Random traffic in the upper half of memory against the model.
        do_reset();
        m_wait = 0; m_owner = 0; pc_v = 0; pd_v = 0; pc_d = 0; pd_d = 0; pc_e = 0;
        e_core = 0; e_dbg = 0; c_req = 0; d_req = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!(c_req && !e_core)) begin
                c_req = ($urandom_range(0, 3) != 0); c_we = $urandom_range(0, 1);
                c_size = 2'($urandom_range(0, 3)); c_uns = $urandom_range(0, 1);
                c_addr = 32'h800 + $urandom_range(0, 32'h7FF); c_wdata = $urandom;
            end
            if (!(d_req && !e_dbg)) begin
                d_req = ($urandom_range(0, 2) == 0); d_we = $urandom_range(0, 1);
                d_lock = $urandom_range(0, 1);
                d_addr = 32'h800 + $urandom_range(0, 32'h7FF); d_wdata = $urandom;
            end
            drive();
            @(negedge clk);
`ifdef DMEM_ARB_DBG_EN
            e_dbg = d_req && (m_owner || m_wait >= STARVE || !c_req);
`else
            e_dbg = 0;
`endif
            e_core = c_req && !e_dbg;
            n = nbytes(c_size);
            mis = (int'(c_addr) % n) != 0;
            chk("rnd_core_gnt", 32'(bus.core_gnt), 32'(e_core));
            chk("rnd_dbg_gnt", 32'(bus.dbg_gnt), 32'(e_dbg));
            chk("rnd_mem_en", 32'(bus.mem_en), 32'((e_core && !mis) || e_dbg));
            chk("rnd_core_rvalid", 32'(bus.core_rvalid), 32'(pc_v));
            chk("rnd_dbg_rvalid", 32'(bus.dbg_rvalid), 32'(pd_v));
            if (pc_v) begin
                chk("rnd_core_rdata", bus.core_rdata, pc_d);
                chk("rnd_core_err", 32'(bus.core_err), 32'(pc_e));
            end
            if (pd_v) chk("rnd_dbg_rdata", bus.dbg_rdata, pd_d);

            pc_v = 0; pd_v = 0;
            if (e_core) begin
                if (mis) begin
                    pc_v = 1; pc_d = 0; pc_e = 1;
                end else if (!c_we) begin
                    pc_v = 1; pc_d = ld_model(int'(c_addr), n, c_uns); pc_e = 0;
                end else begin
                    for (int i = 0; i < n; i++) ref_mem[int'(c_addr) + i] = c_wdata[8*i +: 8];
                end
            end
            if (e_dbg) begin
                wa = int'(d_addr) & ~3;
                if (d_we) for (int i = 0; i < 4; i++) ref_mem[wa + i] = d_wdata[8*i +: 8];
                else begin pd_v = 1; pd_d = ld_model(wa, 4, 1); end
            end
            if (!d_req || e_dbg) m_wait = 0;
            else if (m_wait < STARVE) m_wait++;
            m_owner = d_req && d_lock && (m_owner || e_dbg);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and lane-formatting controller for the single-port data memory of `single_cycle_riscv`. Shares the memory between the core load/store path and a debug/loader port.
- Converts byte/half/word accesses into word-addressed memory cycles with byte write-enables.
- Formats load data with sign or zero extension.
- Sits between the core's execute stage and the data memory; the core stalls on `core_gnt` low.

## Interface
- `STARVE_MAX`, 4: consecutive denied debug cycles before debug wins over core; legal range 1..15.
- `MEM_AW`, 10: word-address width of the data memory.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-low
- `core_req`  in  1  core access request
- `core_we`  in  1  1 = store, 0 = load
- `core_addr`  in  32  byte address
- `core_size`  in  2  00 byte, 01 half, 10 word; 11 treated as word
- `core_unsigned`  in  1  zero-extend load (LBU/LHU)
- `core_wdata`  in  32  store data, LSB-aligned
- `core_gnt`  out  1  access accepted this cycle
- `core_rvalid`  out  1  load data / error response valid
- `core_rdata`  out  32  extended load data
- `core_err`  out  1  misaligned access, valid with `core_rvalid`
- `dbg_req`, `dbg_we`  in  1  debug request / write
- `dbg_addr`  in  32  byte address; bits [1:0] ignored, word only
- `dbg_wdata`  in  32  debug write data
- `dbg_lock`  in  1  hold debug ownership while asserted with `dbg_req`
- `dbg_gnt`, `dbg_rvalid`  out  1  debug grant / read valid
- `dbg_rdata`  out  32  raw read word
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  4  byte write enables
- `mem_addr`  out  MEM_AW  word address, `addr[MEM_AW+1:2]`
- `mem_wdata`  out  32  lane-steered write data
- `mem_rdata`  in  32  read word, valid one cycle after `mem_en`

## Operation
- At most one grant per cycle. Grants are combinational from the requests and the registered state. Memory outputs are driven in the grant cycle.
- Priority:
  - Debug wins if `dbg_owner` is set (debug lock active) or `dbg_wait == STARVE_MAX`.
  - Otherwise core wins.
  - Debug is granted when core is idle.
- `dbg_wait` (4-bit):
  - Increments each cycle with `dbg_req & ~dbg_gnt`, saturating at `STARVE_MAX`.
  - Clears on `dbg_gnt` or `~dbg_req`.
- `dbg_owner`:
  - Set on a `dbg_gnt` with `dbg_lock`.
  - Cleared when `dbg_lock` or `dbg_req` drops.
- Store lane steering:
  - Byte: `mem_we = 1 << addr[1:0]`; the data byte is replicated to all lanes.
  - Half: `mem_we = 0011` or `1100`.
  - Word: `mem_we = 1111`.
  - A debug write always uses `1111`.
- Misaligned core access (half with `addr[0]=1`, word with `addr[1:0]!=0`):
  - `core_gnt` is asserted with `mem_en = 0`.
  - Next cycle `core_rvalid = 1`, `core_err = 1`, `core_rdata = 0`, for loads and stores alike.
- Response register captures owner, size, `addr[1:0]`, unsigned and error at each read grant. The next cycle it selects and extends the byte or half from `mem_rdata`.
- Aligned stores produce no `rvalid`.

## Timing
- Reset (`rst` low at posedge): every output is 0 and all state is 0. This includes `dbg_wait`, `dbg_owner` and the pending-response valid.
- A pending read in flight when reset is asserted produces no `rvalid`.
- Load latency: `*_rvalid` pulses exactly one cycle after the grant cycle, for one cycle.
- Back-to-back reads are legal every cycle; responses return in grant order.
- `core_gnt` low means the core holds its request stable.
- Simultaneous requests with `dbg_wait < STARVE_MAX` and no lock: core granted.
- A debug request held with the core continuously requesting is granted on the cycle after `dbg_wait` reaches `STARVE_MAX`. That is its `STARVE_MAX+1`th requesting cycle.
- `mem_en` is 0 in any cycle with no grant.

## Configuration
- `DMEM_ARB_DBG_EN`
  - Defined: debug port arbitrated as above.
  - Undefined:
    - Debug inputs ignored.
    - `dbg_gnt`, `dbg_rvalid` and `dbg_rdata` tied to 0.
    - Starvation counter and owner logic removed.
    - `core_gnt = core_req`.
  - Port list is identical in both builds.

## Structure
- Package `riscv_mem_pkg`:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - Byte-enable function.
  - Misalignment check function.
  - Response record type {owner, size, offset, unsigned, err}.
- Sub-module `dmem_lane_align`: purely combinational store steering (`mem_we`/`mem_wdata`) and load extraction/extension. Shared with future LSU work.
- Arbitration, counter and response registers stay in `dmem_arbiter`.

## Test plan
- Core SB `addr=0x103`, `wdata=0xA5` → `mem_we=1000`, `mem_wdata=0xA5A5A5A5`, `mem_addr=0x40`.
- Core LH `addr=0x102`, `unsigned=0`, `mem_rdata=0x80017F00` → next cycle `core_rvalid=1`, `core_rdata=0xFFFF8001`. With LHU → `0x00008001`.
- Core LW `addr=0x101` → `core_gnt=1`, `mem_en=0`; next cycle `core_err=1`, `core_rdata=0`.
- Core and debug both requesting continuously, `STARVE_MAX=4` → `dbg_gnt` first high in cycle 5; the core is granted again in cycle 6.
- Debug with `dbg_lock=1` for 3 reads while `core_req=1` → 3 consecutive `dbg_gnt` and 3 `dbg_rvalid`, then the core is granted.
- Reset asserted during a read's grant cycle → no `rvalid` the next cycle; all outputs 0.
